// File: rtl/uv_pm_pkg.sv
// Shared power-management definitions: controller state encoding and defaults.
package uv_pm_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StIdle  = 2'd1,
        StGated = 2'd2,
        StWake  = 2'd3
    } pm_state_e;

    localparam int unsigned DefaultWakeDly = 4;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uv_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module uv_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count up on inc, stick at all ones, clear on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uv_clk_gate_ctrl.sv
// Idle-detect clock gate controller. Runs on the free-running clock and drives the
// registered clk_en of a uv_clk_gate cell, plus a saturating gated-cycle statistic.
module uv_clk_gate_ctrl
    import uv_pm_pkg::*;
#(
    parameter int unsigned IDLE_CNT_W = 8,
    parameter int unsigned WAKE_DLY   = DefaultWakeDly,
    parameter int unsigned STAT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thr,
    input  logic                  busy,
    input  logic                  wake_req,
    input  logic                  stat_clr,
    output logic                  clk_en,
    output logic                  gated,
    output logic                  wake_ack,
    output logic [STAT_W-1:0]     gated_cnt
);

    localparam int unsigned         WakeCntW = cnt_width(WAKE_DLY);
    localparam logic [WakeCntW-1:0] WakeLast = WakeCntW'(WAKE_DLY);

    pm_state_e             state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WakeCntW-1:0]   wake_cnt_q, wake_cnt_d;
    logic                  clk_en_q, gated_q, wake_ack_q, wake_ack_d;
    logic                  wake_cond;

    // Any of these ends an idle run or a gated period.
    assign wake_cond = busy | wake_req | ~cfg_en;

    // Next-state and counter updates; WAKE ignores inputs until the settle window ends.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        wake_ack_d = 1'b0;
        case (state_q)
            StRun: begin
                if (cfg_en && !busy && !wake_req) begin
                    state_d    = StIdle;
                    idle_cnt_d = '0;
                end
            end
            StIdle: begin
                if (wake_cond) begin
                    state_d    = StRun;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= cfg_idle_thr) begin
                    // >= so a lowered threshold gates at once and the count never wraps.
                    state_d = StGated;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
                end
            end
            StGated: begin
                if (wake_cond) begin
                    state_d    = StWake;
                    wake_cnt_d = '0;
                end
            end
            StWake: begin
                if (wake_cnt_q == WakeLast) begin
                    state_d    = StRun;
                    wake_ack_d = 1'b1;
                end else begin
                    wake_cnt_d = wake_cnt_q + WakeCntW'(1);
                end
            end
            default: state_d = StRun;
        endcase
    end

    // State, counters and outputs all registered; outputs decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            clk_en_q   <= 1'b1;
            gated_q    <= 1'b0;
            wake_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            clk_en_q   <= (state_d != StGated);
            gated_q    <= (state_d == StGated);
            wake_ack_q <= wake_ack_d;
        end
    end

    uv_sat_cnt #(
        .W (STAT_W)
    ) u_gated_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (state_q == StGated),
        .cnt   (gated_cnt)
    );

    assign clk_en   = clk_en_q;
    assign gated    = gated_q;
    assign wake_ack = wake_ack_q;

endmodule

// File: tb/tb_uv_clk_gate_ctrl.sv
// Scoreboard bench for uv_clk_gate_ctrl: cycle-stamped expectations are queued by the
// stimulus process and checked by an independent monitor on the falling edge.
module tb_uv_clk_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_en;
    logic [7:0] cfg_idle_thr;
    logic       busy;
    logic       wake_req;
    logic       stat_clr;
    logic       clk_en;
    logic       gated;
    logic       wake_ack;
    logic [3:0] gated_cnt;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic       ce;
        logic       g;
        logic       wa;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    uv_clk_gate_ctrl #(
        .IDLE_CNT_W (8),
        .WAKE_DLY   (4),
        .STAT_W     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_en       (cfg_en),
        .cfg_idle_thr (cfg_idle_thr),
        .busy         (busy),
        .wake_req     (wake_req),
        .stat_clr     (stat_clr),
        .clk_en       (clk_en),
        .gated        (gated),
        .wake_ack     (wake_ack),
        .gated_cnt    (gated_cnt)
    );

    always #5 clk = ~clk;

    // Cycle stamp: number of rising edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic expect_at(input int c, input string nm, input logic ce, input logic g,
                             input logic wa, input logic [3:0] cnt);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.ce   = ce;
        e.g    = g;
        e.wa   = wa;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (cyc >= c) break;
        end
    endtask

    // Monitor: pop every expectation whose stamp has been reached and compare.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: sample for cycle %0d missed, now at cycle %0d",
                         e.name, e.cyc, cyc);
            end else if (clk_en !== e.ce || gated !== e.g || wake_ack !== e.wa ||
                         gated_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s @%0d: got clk_en=%b gated=%b wake_ack=%b cnt=%0d, want %b %b %b %0d",
                         e.name, cyc, clk_en, gated, wake_ack, gated_cnt,
                         e.ce, e.g, e.wa, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        cfg_en       = 1'b0;
        cfg_idle_thr = 8'd3;
        busy         = 1'b0;
        wake_req     = 1'b0;
        stat_clr     = 1'b0;

        // Reset and disabled gating.
        expect_at(0,  "reset",  1, 0, 0, 0);
        expect_at(10, "run10",  1, 0, 0, 0);
        expect_at(30, "run30",  1, 0, 0, 0);
        expect_at(50, "run50",  1, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(50);

        // Enable with thr=3 after edge 50: gate after edge 55.
        expect_at(54, "idle54", 1, 0, 0, 0);
        expect_at(55, "gate55", 0, 1, 0, 0);
        expect_at(56, "cnt56",  0, 1, 0, 1);
        expect_at(58, "cnt58",  0, 1, 0, 3);
        cfg_en = 1'b1;
        wait_cyc(58);

        // One-cycle wake_req in GATED, then re-gate.
        expect_at(59, "wake59", 1, 0, 0, 4);
        expect_at(63, "wake63", 1, 0, 0, 4);
        expect_at(64, "ack64",  1, 0, 1, 4);
        expect_at(65, "ack65",  1, 0, 0, 4);
        expect_at(68, "idle68", 1, 0, 0, 4);
        expect_at(69, "gate69", 0, 1, 0, 4);
        expect_at(70, "cnt70",  0, 1, 0, 5);
        wake_req = 1'b1;
        wait_cyc(59);
        wake_req = 1'b0;
        wait_cyc(70);

        // busy wakes; later busy hits when idle_cnt==thr and must win.
        expect_at(71, "bwake71", 1, 0, 0, 6);
        expect_at(75, "bwake75", 1, 0, 0, 6);
        expect_at(76, "back76",  1, 0, 1, 6);
        expect_at(77, "back77",  1, 0, 0, 6);
        expect_at(82, "idle82",  1, 0, 0, 6);
        expect_at(83, "prio83",  1, 0, 0, 6);
        expect_at(87, "idle87",  1, 0, 0, 6);
        expect_at(88, "gate88",  0, 1, 0, 6);
        busy = 1'b1;
        wait_cyc(78);
        busy = 1'b0;
        wait_cyc(82);
        busy = 1'b1;
        wait_cyc(83);
        busy = 1'b0;

        // Saturation of 4-bit count and clear priority.
        expect_at(97,  "sat97",  0, 1, 0, 15);
        expect_at(100, "sat100", 0, 1, 0, 15);
        expect_at(105, "sat105", 0, 1, 0, 15);
        expect_at(106, "clr106", 0, 1, 0, 0);
        expect_at(107, "clr107", 0, 1, 0, 1);
        expect_at(108, "clr108", 0, 1, 0, 2);
        wait_cyc(105);
        stat_clr = 1'b1;
        wait_cyc(106);
        stat_clr = 1'b0;
        wait_cyc(108);

        // cfg_en drop wakes; thr=0 gates after one IDLE cycle.
        expect_at(109, "dwake109", 1, 0, 0, 3);
        expect_at(113, "dwake113", 1, 0, 0, 3);
        expect_at(114, "dack114",  1, 0, 1, 3);
        expect_at(115, "dack115",  1, 0, 0, 3);
        expect_at(117, "thr0i117", 1, 0, 0, 3);
        expect_at(118, "thr0g118", 0, 1, 0, 3);
        expect_at(119, "thr0c119", 0, 1, 0, 4);
        cfg_en = 1'b0;
        wait_cyc(116);
        cfg_en       = 1'b1;
        cfg_idle_thr = 8'd0;
        wait_cyc(120);

        // wake_req held through WAKE keeps RUN; lowering thr mid-IDLE gates next edge.
        expect_at(121, "hwake121", 1, 0, 0, 6);
        expect_at(126, "hack126",  1, 0, 1, 6);
        expect_at(127, "hrun127",  1, 0, 0, 6);
        expect_at(130, "hrun130",  1, 0, 0, 6);
        expect_at(134, "idle134",  1, 0, 0, 6);
        expect_at(135, "lthr135",  0, 1, 0, 6);
        expect_at(137, "cnt137",   0, 1, 0, 8);
        wake_req = 1'b1;
        wait_cyc(130);
        wake_req     = 1'b0;
        cfg_idle_thr = 8'd10;
        wait_cyc(134);
        cfg_idle_thr = 8'd1;
        wait_cyc(138);

        // Asynchronous reset in GATED, then release into RUN.
        expect_at(0, "arst",   1, 0, 0, 0);
        expect_at(1, "rel1",   1, 0, 0, 0);
        expect_at(2, "rel2",   1, 0, 0, 0);
        expect_at(3, "rel3",   0, 1, 0, 0);
        expect_at(4, "rel4",   0, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        wait_cyc(4);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
